clk_period_meter: RTL and testbench



---
 rtl/clk_period_meter.sv | 120 ++++++++++++
 tb/tb_clk_period_meter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures edge-to-edge interval of a slow input in clk cycles.
// Optional CLK_PERIOD_METER_FULL_PERIOD_EN: count rising edges only (full period).
module clk_period_meter #(
  parameter int CNT_WIDTH   = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 100_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 valid,
  input  logic                 ready,
  output logic                 overrun,
  output logic                 stall
);

  localparam logic [CNT_WIDTH-1:0] LP_TMO = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] LP_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEAS,
    S_STALL
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_edge;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [CNT_WIDTH-1:0]   r_period;
  logic                   r_valid;
  logic                   r_overrun;
  logic                   r_stall;

  logic w_sync;
  logic w_edge;

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef CLK_PERIOD_METER_FULL_PERIOD_EN
  assign w_edge = w_sync & ~r_prev;
`else
  assign w_edge = w_sync ^ r_prev;
`endif

  assign period  = r_period;
  assign valid   = r_valid;
  assign overrun = r_overrun;
  assign stall   = r_stall;

  // synchronize input, keep previous value, register the edge flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_edge <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], in};
      r_prev <= w_sync;
      r_edge <= w_edge;
    end
  end

  // interval counter: reload on counted edge, else saturate at timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_edge) begin
      r_cnt <= LP_ONE;
    end else if (r_cnt != LP_TMO) begin
      r_cnt <= r_cnt + LP_ONE;
    end
  end

  // measurement FSM with registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_stall   <= 1'b0;
    end else begin
      if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
      unique case (r_state)
        S_IDLE: begin
          if (r_edge) begin
            r_state <= S_MEAS;
          end
        end
        S_MEAS: begin
          if (r_edge) begin
            r_period <= r_cnt;
            r_valid  <= 1'b1;
            if (r_valid && !ready) begin
              r_overrun <= 1'b1;
            end
          end else if (r_cnt == LP_TMO) begin
            r_state <= S_STALL;
            r_stall <= 1'b1;
          end
        end
        S_STALL: begin
          if (r_edge) begin
            r_state <= S_MEAS;
            r_stall <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: random stimulus vs. cycle-time reference model.
// Model works on sample-cycle timestamps of input changes.
module tb_clk_period_meter;

  localparam int CW = 16;
  localparam int SS = 2;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          sq_in;
  logic          ready;
  logic [CW-1:0] period;
  logic          valid;
  logic          overrun;
  logic          stall;

  always #5 clk = ~clk;

  clk_period_meter #(
    .CNT_WIDTH  (CW),
    .SYNC_STAGES(SS),
    .TIMEOUT    (TO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .in     (sq_in),
    .period (period),
    .valid  (valid),
    .ready  (ready),
    .overrun(overrun),
    .stall  (stall)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // model state: 0 idle, 1 measuring, 2 stalled
  int ev_q[$];
  int m_mode;
  int m_last;
  int m_period;
  bit m_valid;
  bit m_ovr;
  bit m_stall;
  bit m_in;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               tag, obs, exp, cyc);
    end
  endtask

  task automatic model();
    bit ev;
    bit cap;
    bit cnt_edge;
    int np;
    ev  = 1'b0;
    cap = 1'b0;
    np  = 0;
    if (ev_q.size() > 0 && ev_q[0] == cyc) begin
      ev = 1'b1;
      void'(ev_q.pop_front());
    end
    if (rst) begin
      ev_q.delete();
      m_mode   = 0;
      m_last   = 0;
      m_period = 0;
      m_valid  = 1'b0;
      m_ovr    = 1'b0;
      m_stall  = 1'b0;
      m_in     = 1'b0;
      return;
    end
    if (ev) begin
      if (m_mode == 1) begin
        cap = 1'b1;
        np  = cyc - m_last;
      end else begin
        m_mode  = 1;
        m_stall = 1'b0;
      end
      m_last = cyc;
    end else if (m_mode == 1 && cyc - m_last == TO) begin
      m_mode  = 2;
      m_stall = 1'b1;
    end
    if (cap) begin
      if (m_valid && !ready) m_ovr = 1'b1;
      m_period = np;
      m_valid  = 1'b1;
    end else if (m_valid && ready) begin
      m_valid = 1'b0;
    end
`ifdef CLK_PERIOD_METER_FULL_PERIOD_EN
    cnt_edge = sq_in && !m_in;
`else
    cnt_edge = sq_in != m_in;
`endif
    if (cnt_edge) ev_q.push_back(cyc + SS + 1);
    m_in = sq_in;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model();
    #1;
    check("period", 32'(period), 32'(m_period));
    check("valid", 32'(valid), 32'(m_valid));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("stall", 32'(stall), 32'(m_stall));
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  task automatic tog(input int n);
    sq_in = ~sq_in;
    hold(n);
  endtask

  initial begin
    rst   = 1'b1;
    sq_in = 1'b0;
    ready = 1'b1;
    hold(2);
    rst = 1'b0;
    hold(3);

    repeat (8) tog(5);

    ready = 1'b0;
    tog(5);
    tog(7);
    tog(7);
    ready = 1'b1;
    step();
    ready = 1'b0;
    hold(2);

    for (int i = 0; i < 10 && !(m_valid && m_ovr); i++) tog(5);
    check("pre_rst_state", 32'({m_valid, m_ovr}), 32'(2'b11));
    rst = 1'b1;
    step();
    rst = 1'b0;
    tog(5);
    tog(5);

    ready = 1'b0;
    tog(5);
    tog(5);
    sq_in = ~sq_in;
    hold(3);
    ready = 1'b1;
    step();
    ready = 1'b0;
    hold(4);
    ready = 1'b1;

    repeat (3) tog(5);
    hold(30);
    repeat (5) tog(4);

    for (int i = 0; i < 80; i++) begin
      int n;
      sq_in = ~sq_in;
      n = int'($urandom_range(2, 26));
      for (int j = 0; j < n; j++) begin
        ready = 1'($urandom_range(0, 1));
        step();
      end
    end

    ready = 1'b1;
    hold(4);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
